// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit little-endian word count, then packs stream bytes into
// 32-bit little-endian words for the imem write port. Optional checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH     = 128,
    parameter int BASE_WORD = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_write,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd4;
`endif
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [31:0] CAP_WORDS = 32'(DEPTH - BASE_WORD);
    localparam logic [31:0] BASE_ADDR = 32'(BASE_WORD);

    logic [2:0]  state_r;
    logic [15:0] len_r;
    logic [15:0] word_idx_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] word_buf_r;
    logic        imem_write_r;
    logic [31:0] imem_addr_r;
    logic [31:0] imem_data_r;
    logic        cpu_hold_r;
    logic        busy_r;
    logic        done_r;
    logic        error_r;
    logic        rx_ready_s;
    logic        accept_s;
    logic [15:0] hdr_len_s;
    logic        last_word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_r;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    assign accept_s    = rx_valid & rx_ready_s;
    assign hdr_len_s   = {rx_data, len_r[7:0]};
    assign last_word_s = (word_idx_r == (len_r - 16'd1));

    assign rx_ready   = rx_ready_s;
    assign imem_write = imem_write_r;
    assign imem_addr  = imem_addr_r;
    assign imem_data  = imem_data_r;
    assign cpu_hold   = cpu_hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;

    // Byte acceptance depends only on the state, never on rx_valid.
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_r)
            S_LEN_LO, S_LEN_HI, S_DATA: rx_ready_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM:                     rx_ready_s = 1'b1;
`endif
            default:                    rx_ready_s = 1'b0;
        endcase
    end

    // Load sequencer, word assembly and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            len_r        <= 16'h0000;
            word_idx_r   <= 16'h0000;
            byte_cnt_r   <= 2'd0;
            word_buf_r   <= 24'h000000;
            imem_write_r <= 1'b0;
            imem_addr_r  <= 32'h0000_0000;
            imem_data_r  <= 32'h0000_0000;
            cpu_hold_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'h00;
`endif
        end else begin
            imem_write_r <= 1'b0;
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_r    <= S_LEN_LO;
                        byte_cnt_r <= 2'd0;
                        word_idx_r <= 16'h0000;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                        cpu_hold_r <= 1'b1;
                        busy_r     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= 8'h00;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (accept_s) begin
                        len_r[7:0] <= rx_data;
                        state_r    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept_s) begin
                        len_r[15:8] <= rx_data;
                        if ({16'h0000, hdr_len_s} > CAP_WORDS) begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                            busy_r  <= 1'b0;
                        end else if (hdr_len_s == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r    <= S_CSUM;
`else
                            state_r    <= S_DONE;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                            busy_r     <= 1'b0;
`endif
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r     <= csum_step(csum_r, rx_data);
`endif
                        case (byte_cnt_r)
                            2'd0:    word_buf_r[7:0]   <= rx_data;
                            2'd1:    word_buf_r[15:8]  <= rx_data;
                            2'd2:    word_buf_r[23:16] <= rx_data;
                            default: begin
                                imem_write_r <= 1'b1;
                                imem_addr_r  <= BASE_ADDR + {16'h0000, word_idx_r};
                                imem_data_r  <= {rx_data, word_buf_r};
                                word_idx_r   <= word_idx_r + 16'd1;
                                // Status flips on the same edge as the final write.
                                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_r    <= S_CSUM;
`else
                                    state_r    <= S_DONE;
                                    done_r     <= 1'b1;
                                    cpu_hold_r <= 1'b0;
                                    busy_r     <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept_s) begin
                        busy_r <= 1'b0;
                        if (rx_data == csum_r) begin
                            state_r    <= S_DONE;
                            done_r     <= 1'b1;
                            cpu_hold_r <= 1'b0;
                        end else begin
                            state_r <= S_ERR;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_r    <= S_IDLE;
                    busy_r     <= 1'b0;
                    cpu_hold_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
